// File: rtl/merge_sort_host.sv
// Host-side driver for the field-ordering merge sorter: loads tagged keys, starts a sort,
// and streams the resulting index permutation out through a 2-entry skid FIFO.
module merge_sort_host #(
  parameter int INT_WIDTH   = 32,
  parameter int INDEX_WIDTH = 13,
  parameter int LIST_LEN    = 8192,
  parameter int K           = $clog2(LIST_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INT_WIDTH-1:0]           in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INDEX_WIDTH-1:0]         out_index,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           fail,
  output logic                           sort_wr_en,
  output logic [K-1:0]                   sort_wr_addr,
  output logic [INT_WIDTH+INDEX_WIDTH-1:0] sort_data_in,
  output logic                           sort_start,
  output logic                           sort_rd_en,
  output logic [K-1:0]                   sort_rd_addr,
  input  logic [INT_WIDTH+INDEX_WIDTH-1:0] sort_data_out,
  input  logic                           sort_done,
  input  logic                           sort_fail
);

  localparam logic [K-1:0] WR_LAST = K'(LIST_LEN - 1);
  localparam logic [K:0]   RD_END  = (K+1)'(LIST_LEN);
  localparam logic [K:0]   RD_LAST = (K+1)'(LIST_LEN - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_SORT, ST_READ} state_t;

  state_t                            state_q;
  logic [K-1:0]                      wcnt_q;
  logic [K:0]                        rcnt_q;
  logic                              sort_first_q;
  logic                              in_ready_q;
  logic                              sort_wr_en_q;
  logic [K-1:0]                      sort_wr_addr_q;
  logic [INT_WIDTH+INDEX_WIDTH-1:0]  sort_data_in_q;
  logic                              sort_start_q;
  logic                              done_q;
  logic                              fail_q;
  logic                              pend_q;
  logic                              pend_last_q;
  logic [INDEX_WIDTH-1:0]            fifo_idx_q  [2];
  logic                              fifo_last_q [2];
  logic                              fifo_rd_ptr_q;
  logic                              fifo_wr_ptr_q;
  logic [1:0]                        fifo_cnt_q;

  logic       in_fire;
  logic       push;
  logic       pop;
  logic [2:0] occ_after_pop;
  logic       rd_issue;
  logic       unused_key_bits;

  assign in_fire   = in_valid && in_ready_q;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = pend_q;

  // Credit the pop in the same cycle so a read can be issued every cycle at full rate.
  assign occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign rd_issue      = (state_q == ST_READ) && (rcnt_q < RD_END) && (occ_after_pop < 3'd2);

  assign sort_rd_en   = rd_issue;
  assign sort_rd_addr = rcnt_q[K-1:0];

  assign in_ready     = in_ready_q;
  assign out_index    = fifo_idx_q[fifo_rd_ptr_q];
  assign out_last     = out_valid && fifo_last_q[fifo_rd_ptr_q];
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign fail         = fail_q;
  assign sort_wr_en   = sort_wr_en_q;
  assign sort_wr_addr = sort_wr_addr_q;
  assign sort_data_in = sort_data_in_q;
  assign sort_start   = sort_start_q;

  assign unused_key_bits = ^sort_data_out[INT_WIDTH+INDEX_WIDTH-1:INDEX_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wcnt_q         <= '0;
      rcnt_q         <= '0;
      sort_first_q   <= 1'b0;
      in_ready_q     <= 1'b0;
      sort_wr_en_q   <= 1'b0;
      sort_wr_addr_q <= '0;
      sort_data_in_q <= '0;
      sort_start_q   <= 1'b0;
      done_q         <= 1'b0;
      fail_q         <= 1'b0;
      pend_q         <= 1'b0;
      pend_last_q    <= 1'b0;
      fifo_rd_ptr_q  <= 1'b0;
      fifo_wr_ptr_q  <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      // NOTE: the two FIFO slots drive out_index directly, so they are reset to keep it 0 after reset.
      for (int i = 0; i < 2; i++) begin
        fifo_idx_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      // NOTE: pulse outputs default low here; a later non-blocking assignment in this block wins.
      sort_wr_en_q <= 1'b0;
      sort_start_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;

      pend_q <= rd_issue;
      if (rd_issue) begin
        pend_last_q <= (rcnt_q == RD_LAST);
        rcnt_q      <= rcnt_q + (K+1)'(1);
      end

      if (push) begin
        fifo_idx_q[fifo_wr_ptr_q]  <= sort_data_out[INDEX_WIDTH-1:0];
        fifo_last_q[fifo_wr_ptr_q] <= pend_last_q;
        fifo_wr_ptr_q              <= ~fifo_wr_ptr_q;
      end
      if (pop) fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      case (state_q)
        ST_IDLE, ST_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            sort_wr_en_q   <= 1'b1;
            sort_wr_addr_q <= wcnt_q;
            sort_data_in_q <= {in_data, INDEX_WIDTH'(wcnt_q)};
            if (wcnt_q == WR_LAST) begin
              wcnt_q     <= '0;
              in_ready_q <= 1'b0;
              state_q    <= ST_START;
            end else begin
              wcnt_q  <= wcnt_q + K'(1);
              state_q <= ST_LOAD;
            end
          end
        end
        ST_START: begin
          sort_start_q <= 1'b1;
          sort_first_q <= 1'b1;
          state_q      <= ST_SORT;
        end
        ST_SORT: begin
          // The sticky fail flag still reflects the previous run during the start cycle.
          sort_first_q <= 1'b0;
          if (sort_fail && !sort_first_q) begin
            fail_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (sort_done) begin
            rcnt_q  <= '0;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (pop && out_last) begin
            done_q     <= 1'b1;
            in_ready_q <= 1'b1;
            rcnt_q     <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/merge_sort_host.md
Name: merge_sort_host

Overview:
- Host-side driver for the field-ordering merge sorter; it is the other end of the sorter's load/start/readback interface.
- Accepts a stream of LIST_LEN random integers and tags each with its arrival index.
- Writes the tagged words into the sorter, pulses start and waits for done or fail.
- Reads the sorted list back and streams out the index permutation, which feeds downstream field-ordering logic.

Parameters:
- INT_WIDTH, 32, width of each random integer (sort key).
- INDEX_WIDTH, 13, width of the index tag; 2^INDEX_WIDTH >= LIST_LEN.
- LIST_LEN, 8192, number of elements per sort; must be a power of two.
- k, CLOG2(LIST_LEN), sorter address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input key valid.
- in_ready  out  1  block can accept a key.
- in_data  in  INT_WIDTH  random key.
- out_valid  out  1  output index valid.
- out_ready  in  1  downstream accepts the index.
- out_index  out  INDEX_WIDTH  original position of the next-smallest key.
- out_last  out  1  marks element LIST_LEN-1 of the output stream.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last index is accepted.
- fail  out  1  one-cycle pulse when the sorter reports a key collision.
- sort_wr_en  out  1  sorter load write enable.
- sort_wr_addr  out  k  sorter load address.
- sort_data_in  out  INT_WIDTH+INDEX_WIDTH  word written to the sorter, {key, index}.
- sort_start  out  1  sorter start pulse.
- sort_rd_en  out  1  sorter read enable.
- sort_rd_addr  out  k  sorter read address.
- sort_data_out  in  INT_WIDTH+INDEX_WIDTH  sorter read data.
- sort_done  in  1  sorter done pulse.
- sort_fail  in  1  sorter fail flag; sticky until the next sort_start.

Behaviour:
- Reset:
  - Asynchronous on rst high: state=IDLE, all counters 0.
  - All outputs 0: in_ready, out_valid, out_last, busy, done, fail, sort_wr_en, sort_start, sort_rd_en. Addresses and data are 0.
  - The sorter has no reset. A later sort_start restarts it.
- States: IDLE, LOAD, START, SORT, READ.
- in_ready is high only in IDLE and LOAD.
- IDLE and LOAD (load path):
  - Each handshake (in_valid && in_ready) registers sort_wr_en=1, sort_wr_addr=wcnt and sort_data_in={in_data, wcnt[INDEX_WIDTH-1:0]} for exactly one cycle, then increments wcnt.
  - Write latency is 1 cycle.
  - The first handshake moves IDLE to LOAD.
  - The handshake with wcnt==LIST_LEN-1 moves to START, clears wcnt and drops in_ready the next cycle.
  - in_valid gaps are allowed.
- START:
  - sort_start=1 for exactly one cycle. This cycle follows the last write, so the last write is already committed.
  - Then moves to SORT.
- SORT:
  - Waits for sort_fail or sort_done. sort_fail has priority if both are high in the same cycle.
  - sort_fail: fail pulses 1 cycle and the state returns to IDLE. No outputs are produced; the caller re-supplies keys.
  - sort_done: moves to READ with rcnt=0.
  - sort_done and sort_fail are ignored in every other state, including stale events from a run aborted by rst.
  - sort_fail is only sampled from the second SORT cycle onward, because the flag is stale until the sorter clears it after start.
- READ:
  - Sorter read latency is 1 cycle: sort_data_out is valid the cycle after sort_rd_en=1 with sort_rd_addr.
  - A 2-entry output FIFO holds sort_data_out[INDEX_WIDTH-1:0] plus a last flag.
  - A read is issued (sort_rd_en=1, sort_rd_addr=rcnt, rcnt++) only when FIFO occupancy + in-flight reads < 2 and rcnt < LIST_LEN.
  - FIFO push and pop may occur in the same cycle.
  - out_valid = FIFO not empty. out_index and out_last come from the FIFO head and are held stable while out_valid && !out_ready.
  - out_last is set for the entry read from address LIST_LEN-1.
  - When the out_last entry is accepted: done pulses 1 cycle and the state moves to IDLE.
  - Full throughput: 1 index/cycle with out_ready held high, after a 2-cycle initial latency from entering READ.
- No data is dropped or duplicated under any out_ready pattern.

Test Plan (LIST_LEN=8, INT_WIDTH=8, INDEX_WIDTH=3, sorter model or real merge sorter):
1. Load keys 50,10,70,30,20,60,40,0 with in_valid held high -> sort_wr_addr 0..7 with sort_data_in = {50,0},{10,1},...,{0,7}; exactly one sort_start pulse; after sort_done with out_ready=1 -> out_index 7,1,4,3,6,0,5,2 on consecutive cycles, out_last on index 2, one done pulse, busy low afterwards.
2. Same keys, out_ready randomly toggled (50% duty) -> identical 8-index sequence, head held stable during stalls, no drops or duplicates.
3. Keys containing duplicate 30 at positions 1 and 5 -> fail pulses once, out_valid never asserts, state back to IDLE; a following valid load sorts correctly.
4. Assert rst during SORT, then load a new 8-key set while the old sorter run finishes -> stale sort_done ignored during LOAD; new start issued; output matches the new set.
5. in_valid with random gaps, plus in_valid held high during START, SORT and READ -> no extra writes (in_ready low); exactly 8 sort_wr_en pulses.
6. sort_done and sort_fail asserted in the same cycle in SORT -> fail pulse only, no READ entry.
